// File: rtl/dp_ram_pipe.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// optional output register stage, same-address write arbitration and a post-reset clear sweep.
module dp_ram_pipe #(
    parameter int DW       = 32,
    parameter int AW       = 10,
    parameter int WR_FIRST = 0,
    parameter int OUT_REG  = 0,
    parameter int CLR_INIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ready,
    input  logic            ena,
    input  logic [DW/8-1:0] wea,
    input  logic [AW-1:0]   addra,
    input  logic [DW-1:0]   dina,
    output logic [DW-1:0]   douta,
    output logic            vala,
    input  logic            enb,
    input  logic [DW/8-1:0] web,
    input  logic [AW-1:0]   addrb,
    input  logic [DW-1:0]   dinb,
    output logic [DW-1:0]   doutb,
    output logic            valb,
    output logic            collision,
    output logic [7:0]      coll_cnt
);
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_clr_addr;
    logic            r_ready;
    logic            w_clr_we;
    logic            r_collision;
    logic [7:0]      r_coll_cnt;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   w_old_a, w_old_b;
    logic [DW-1:0]   w_upd_a, w_upd_b;
    logic            w_wr_a, w_wr_b, w_same, w_both_wr;
    logic [1:0]      w_acc;
    logic [DW-1:0]   w_rd   [2];
    logic [DW-1:0]   w_dout [2];
    logic [1:0]      w_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= (CLR_INIT != 0) ? S_CLEAR : S_RUN;
            r_clr_addr <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == S_RUN);
            if (r_state == S_CLEAR)
                r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr_we     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we = 1'b1;
                if (&r_clr_addr)
                    w_state_next = S_RUN;
            end
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_CLEAR;
        endcase
    end

    assign ready     = r_ready;
    assign w_acc     = {enb & r_ready, ena & r_ready};
    assign w_wr_a    = w_acc[0] & (|wea);
    assign w_wr_b    = w_acc[1] & (|web);
    assign w_same    = (addra == addrb);
    assign w_both_wr = w_wr_a & w_wr_b & w_same;
    assign w_old_a   = r_mem[addra];
    assign w_old_b   = r_mem[addrb];

    // Each w_upd_x is the final word stored at that port's address this cycle;
    // on a shared address port A's enabled lanes override port B's.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign w_upd_a[8*gi +: 8] = (w_wr_a && wea[gi])           ? dina[8*gi +: 8] :
                                        (w_wr_b && w_same && web[gi]) ? dinb[8*gi +: 8] :
                                                                        w_old_a[8*gi +: 8];
            assign w_upd_b[8*gi +: 8] = (w_wr_a && w_same && wea[gi]) ? dina[8*gi +: 8] :
                                        (w_wr_b && web[gi])           ? dinb[8*gi +: 8] :
                                                                        w_old_b[8*gi +: 8];
        end
    endgenerate

    assign w_rd[0] = (WR_FIRST != 0) ? w_upd_a : w_old_a;
    assign w_rd[1] = (WR_FIRST != 0) ? w_upd_b : w_old_b;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= '0;
        end else begin
            if (w_wr_a) r_mem[addra] <= w_upd_a;
            if (w_wr_b) r_mem[addrb] <= w_upd_b;
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DW-1:0] r_dout_s1;
            logic          r_val_s1;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout_s1 <= '0;
                    r_val_s1  <= 1'b0;
                end else begin
                    r_val_s1 <= w_acc[gi];
                    if (w_acc[gi])
                        r_dout_s1 <= w_rd[gi];
                end
            end

            if (OUT_REG != 0) begin : g_oreg
                logic [DW-1:0] r_dout_s2;
                logic          r_val_s2;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_dout_s2 <= '0;
                        r_val_s2  <= 1'b0;
                    end else begin
                        r_val_s2 <= r_val_s1;
                        if (r_val_s1)
                            r_dout_s2 <= r_dout_s1;
                    end
                end
                assign w_dout[gi] = r_dout_s2;
                assign w_val[gi]  = r_val_s2;
            end else begin : g_noreg
                assign w_dout[gi] = r_dout_s1;
                assign w_val[gi]  = r_val_s1;
            end
        end
    endgenerate

    assign douta = w_dout[0];
    assign vala  = w_val[0];
    assign doutb = w_dout[1];
    assign valb  = w_val[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision <= 1'b0;
            r_coll_cnt  <= '0;
        end else begin
            r_collision <= w_both_wr;
            if (w_both_wr && (r_coll_cnt != 8'hFF))
                r_coll_cnt <= r_coll_cnt + 8'd1;
        end
    end

    assign collision = r_collision;
    assign coll_cnt  = r_coll_cnt;
endmodule

// File: tb/tb_dp_ram_pipe.sv
// Scoreboard bench: dut1 is the default read-first, latency-1 RAM (1024 words);
// dut2 is a 16-word write-first RAM with the extra output register.
module tb_dp_ram_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        ready, ena, enb, vala, valb, collision;
    logic [3:0]  wea, web;
    logic [9:0]  addra, addrb;
    logic [31:0] dina, dinb, douta, doutb;
    logic [7:0]  coll_cnt;

    logic        ready2, ena2, enb2, vala2, valb2, collision2;
    logic [3:0]  wea2, web2;
    logic [3:0]  addra2, addrb2;
    logic [31:0] dina2, dinb2, douta2, doutb2;
    logic [7:0]  coll_cnt2;

    dp_ram_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .vala(vala),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .valb(valb),
        .collision(collision), .coll_cnt(coll_cnt)
    );

    dp_ram_pipe #(.DW(32), .AW(4), .WR_FIRST(1), .OUT_REG(1), .CLR_INIT(1)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .ready(ready2),
        .ena(ena2), .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2), .vala(vala2),
        .enb(enb2), .web(web2), .addrb(addrb2), .dinb(dinb2), .doutb(doutb2), .valb(valb2),
        .collision(collision2), .coll_cnt(coll_cnt2)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        qa[$], qb[$], qa2[$], qb2[$];
    exp_t        m_a, m_b, m_a2, m_b2;
    logic [31:0] mdl  [1024];
    logic [31:0] mdl2 [16];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (we[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    // Read-first model: results are the words before this cycle's writes; B applied, then A on top.
    task automatic d1(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db);
        exp_t e;
        @(negedge clk);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        e.due = cyc + 1;
        if (ea) begin e.d = mdl[aa]; qa.push_back(e); end
        if (eb) begin e.d = mdl[ab]; qb.push_back(e); end
        if (eb) mdl[ab] = merge(mdl[ab], db, wb);
        if (ea) mdl[aa] = merge(mdl[aa], da, wa);
    endtask

    // Write-first model: results are the words after this cycle's writes.
    task automatic d2(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
        exp_t e;
        @(negedge clk);
        ena2 = ea; wea2 = wa; addra2 = aa; dina2 = da;
        enb2 = eb; web2 = wb; addrb2 = ab; dinb2 = db;
        if (eb) mdl2[ab] = merge(mdl2[ab], db, wb);
        if (ea) mdl2[aa] = merge(mdl2[aa], da, wa);
        e.due = cyc + 2;
        if (ea) begin e.d = mdl2[aa]; qa2.push_back(e); end
        if (eb) begin e.d = mdl2[ab]; qb2.push_back(e); end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ena = 1'b0; enb = 1'b0; ena2 = 1'b0; enb2 = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (vala) begin
            if (qa.size() == 0) chk("a_spurious", 1, 0);
            else begin m_a = qa.pop_front(); chk("a_data", douta, m_a.d); chk("a_lat", cyc, m_a.due); end
        end
        if (valb) begin
            if (qb.size() == 0) chk("b_spurious", 1, 0);
            else begin m_b = qb.pop_front(); chk("b_data", doutb, m_b.d); chk("b_lat", cyc, m_b.due); end
        end
        if (vala2) begin
            if (qa2.size() == 0) chk("a2_spurious", 1, 0);
            else begin m_a2 = qa2.pop_front(); chk("a2_data", douta2, m_a2.d); chk("a2_lat", cyc, m_a2.due); end
        end
        if (valb2) begin
            if (qb2.size() == 0) chk("b2_spurious", 1, 0);
            else begin m_b2 = qb2.pop_front(); chk("b2_data", doutb2, m_b2.d); chk("b2_lat", cyc, m_b2.due); end
        end
    end

    initial begin
        int cnt;
        rst_n = 1'b0; rst2_n = 1'b0;
        ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0; dina = 0; dinb = 0;
        ena2 = 0; enb2 = 0; wea2 = 0; web2 = 0; addra2 = 0; addrb2 = 0; dina2 = 0; dinb2 = 0;
        for (int i = 0; i < 1024; i++) mdl[i] = '0;
        for (int i = 0; i < 16; i++) mdl2[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_douta", douta, 0);
        chk("rst_vala", vala, 0);
        chk("rst_doutb", doutb, 0);
        chk("rst_valb", valb, 0);
        chk("rst_coll", collision, 0);
        chk("rst_cnt", coll_cnt, 0);
        chk("rst_ready2", ready2, 0);
        rst_n = 1'b1; rst2_n = 1'b1;

        cnt = 0;
        while (!ready && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("ready_lat", cnt, 1024);
        chk("ready2_up", ready2, 1);

        // Sweep left the top word zero
        d1(1, 4'h0, 10'h3FF, 0, 1, 4'h0, 10'h000, 0);
        // Byte-lane merge
        d1(1, 4'hF, 10'd5, 32'h11223344, 0, 4'h0, 0, 0);
        d1(1, 4'b0101, 10'd5, 32'hDEADBEEF, 0, 4'h0, 0, 0);
        d1(1, 4'h0, 10'd5, 0, 0, 4'h0, 0, 0);
        idle(3);
        chk("merge_hold", douta, 32'h11AD33EF);
        // A writes while B reads the same word: B sees the old word
        d1(1, 4'hF, 10'd7, 32'h55667788, 0, 4'h0, 0, 0);
        d1(1, 4'hF, 10'd7, 32'hAAAAAAAA, 1, 4'h0, 10'd7, 0);
        idle(2);
        chk("rf_b_old", doutb, 32'h55667788);
        // Dual write to one address: A's lane wins, others from B
        d1(1, 4'b0001, 10'd9, 32'h000000FF, 1, 4'hF, 10'd9, 32'h12345678);
        idle(1);
        chk("coll_pulse", collision, 1);
        chk("coll_cnt1", coll_cnt, 1);
        idle(1);
        chk("coll_drop", collision, 0);
        d1(1, 4'h0, 10'd9, 0, 0, 4'h0, 0, 0);
        idle(2);
        chk("coll_word", douta, 32'h123456FF);
        // Counter saturation
        for (int i = 0; i < 300; i++)
            d1(1, 4'($urandom_range(1, 15)), 10'd9, $urandom, 1, 4'($urandom_range(1, 15)), 10'd9, $urandom);
        idle(2);
        chk("coll_sat", coll_cnt, 255);
        // Random traffic over a small window to provoke cross-port hits
        for (int i = 0; i < 80; i++)
            d1(1'($urandom), 4'($urandom), 10'($urandom_range(0, 15)), $urandom,
               1'($urandom), 4'($urandom), 10'($urandom_range(0, 15)), $urandom);
        idle(3);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        // dut2: write-first cross-port read
        d2(1, 4'hF, 4'd7, 32'hAAAAAAAA, 1, 4'h0, 4'd7, 0);
        idle(3);
        chk("wf_b_new", doutb2, 32'hAAAAAAAA);
        // Back-to-back writes then reads at latency 2
        for (int i = 1; i <= 4; i++) d2(1, 4'hF, 4'(i), 32'hC0DE0000 + i, 0, 4'h0, 0, 0);
        for (int i = 1; i <= 4; i++) d2(1, 4'h0, 4'(i), 0, 0, 4'h0, 0, 0);
        idle(3);
        chk("drain_a2", qa2.size(), 0);
        // Reset with reads in flight
        d2(1, 4'h0, 4'd1, 0, 0, 4'h0, 0, 0);
        d2(1, 4'h0, 4'd2, 0, 0, 4'h0, 0, 0);
        idle(1);
        #2 rst2_n = 1'b0;
        #1;
        chk("midrst_val", vala2, 0);
        chk("midrst_dout", douta2, 0);
        chk("midrst_ready", ready2, 0);
        qa2.delete(); qb2.delete();
        for (int i = 0; i < 16; i++) mdl2[i] = '0;
        idle(2);
        rst2_n = 1'b1;
        cnt = 0;
        while (!ready2 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("ready2_lat", cnt, 16);
        d2(1, 4'h0, 4'd7, 0, 1, 4'h0, 4'd1, 0);
        idle(4);
        chk("drain_a2_end", qa2.size(), 0);
        chk("drain_b2_end", qb2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
